// File: rtl/branch_predictor_btb.sv
// Branch predictor with a direct-mapped branch target buffer.
// The IF stage looks up a PC and gets a predicted next PC in the same cycle.
// The EX stage writes back the resolved outcome, gets a same-cycle mispredict
// flag, and bumps saturating performance counters.
module branch_predictor_btb #(
  parameter int ENTRIES  = 16,
  parameter int ADDR_W   = 32,
  parameter int CTR_BITS = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [PERF_W-1:0] branch_count,
  output logic [PERF_W-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  // A new entry starts weakly taken; reset leaves every counter weakly not-taken.
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0]               valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]    tag_q;
  logic [ENTRIES-1:0][ADDR_W-1:0]   tgt_q;
  logic [ENTRIES-1:0][CTR_BITS-1:0] ctr_q;
  logic [PERF_W-1:0]                branch_cnt_q, branch_cnt_d;
  logic [PERF_W-1:0]                mispred_cnt_q, mispred_cnt_d;

  // The two low PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[ADDR_W-1:IDX_W+2];

  // Predict from registered state only; a same-cycle update is not bypassed.
  always_comb begin
    pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken   = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_next_pc = pred_taken ? tgt_q[lk_idx] : (if_pc + ADDR_W'(4));
  end

  // Update side
  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic                ent_we;
  logic [CTR_BITS-1:0] ctr_d;
  logic [ADDR_W-1:0]   tgt_d;
  logic [TAG_W-1:0]    tag_d;
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  // Next-state of the single entry addressed by the resolved instruction.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ent_we  = 1'b0;
    ctr_d   = ctr_q[upd_idx];
    tgt_d   = tgt_q[upd_idx];
    tag_d   = tag_q[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        ent_we = 1'b1;
        if (upd_taken) begin
          tgt_d = upd_target;
          if (ctr_q[upd_idx] != CTR_MAX) ctr_d = ctr_q[upd_idx] + CTR_BITS'(1);
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_d = ctr_q[upd_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        // Allocate, evicting whatever aliased into this slot.
        ent_we = 1'b1;
        ctr_d  = CTR_WT;
        tgt_d  = upd_target;
        tag_d  = upd_tag;
      end
    end
  end

  // Saturating performance counter next-state.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + PERF_W'(1);
    if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
  end

  // BTB storage and counters; reset wins over any update in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      tag_q         <= '0;
      tgt_q         <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (ent_we) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= tag_d;
        tgt_q[upd_idx]   <= tgt_d;
        ctr_q[upd_idx]   <= ctr_d;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised dynamic branch predictor with a branch target buffer (BTB) for the 5-stage MIPS pipeline.
- IF stage: looks up the current PC and predicts the next PC combinationally, so taken branches and jumps need not flush IF/ID.
- EX stage: updates the predictor with the resolved outcome, raises a same-cycle mispredict flag for the flush logic, and keeps saturating performance counters.
- Replaces the static "predict not-taken, flush on Branch&&Zero" policy.

Parameters:
- ENTRIES, 16: number of BTB entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- ADDR_W, 32: PC / target width.
- CTR_BITS, 2: width of each saturating direction counter; at least 1.
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- if_pc  in  ADDR_W  PC being fetched
- pred_hit  out  1  valid entry whose tag matches if_pc
- pred_taken  out  1  prediction is taken
- pred_next_pc  out  ADDR_W  predicted next PC
- upd_valid  in  1  EX-stage resolved control-transfer instruction this cycle
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual target (ignored when not taken)
- upd_pred_taken  in  1  prediction originally made for this instruction
- upd_pred_target  in  ADDR_W  pred_next_pc originally supplied for it
- mispredict  out  1  combinational flush request
- branch_count  out  PERF_W  resolved-instruction count
- mispredict_count  out  PERF_W  misprediction count

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] is ignored.
- Entry contents: valid, tag, target, ctr[CTR_BITS].
- Lookup (combinational from registered state):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && ctr MSB.
  - pred_next_pc = pred_taken ? target : if_pc+4, computed modulo 2^ADDR_W.
- mispredict = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)).
  - Combinational, same cycle as upd_valid.
- Update on posedge clk when upd_valid:
  - Entry hit, taken: ctr saturating +1 (caps at all-ones); target <= upd_target.
  - Entry hit, not taken: ctr saturating -1 (floors at 0); target unchanged.
  - Entry miss, taken: allocate. valid=1, tag and target written, ctr = 2^(CTR_BITS-1) (weakly taken). Overwrites any aliasing entry.
  - Entry miss, not taken: no change.
- Performance counters, on posedge when upd_valid:
  - branch_count += 1.
  - mispredict_count += mispredict.
  - Both saturate at all-ones and do not wrap.
- Simultaneous lookup and update of the same index: lookup sees pre-update state; no bypass. The update is visible from the next cycle.
- Only one update port; every cycle is either a single update or none.
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - All valid = 0; all ctr = 2^(CTR_BITS-1)-1 (weakly not-taken); targets and tags are don't-care.
  - branch_count = mispredict_count = 0.
  - Outputs during reset: pred_hit = 0, pred_taken = 0, pred_next_pc = if_pc+4. mispredict still follows its equation.
- Updates arriving while reset is asserted are dropped.
- CTR_BITS=1 reduces to a last-outcome predictor: alloc ctr=1, reset ctr=0.

Test Plan (ENTRIES=16, CTR_BITS=2):
- Reset, if_pc=0x00400010 -> pred_hit=0, pred_taken=0, pred_next_pc=0x00400014; both counters 0.
- Update upd_pc=0x00400010, taken, upd_target=0x00400040, upd_pred_taken=0:
  - Same cycle: mispredict=1.
  - Next cycle, lookup 0x00400010: hit=1, taken=1, next_pc=0x00400040; branch_count=1, mispredict_count=1.
- Same PC, two not-taken updates with upd_pred_taken matching the prevailing prediction:
  - ctr goes 2 -> 1 -> 0; pred_taken=0 after the first.
  - First update: mispredict=1 (predicted taken). Second: mispredict=0. Counts become 3/2.
- Same PC, four taken updates -> ctr saturates at 3. One not-taken -> ctr=2, pred_taken still 1.
- Alias: after allocating 0x00400010, taken update at 0x00400050 (same index 4) -> lookup 0x00400010 gives hit=0, next_pc=0x00400014; lookup 0x00400050 gives hit=1.
- Same-cycle conflict: if_pc=upd_pc=0x00400010 with allocating update -> pred_hit=0 that cycle, 1 the next.
- Assert reset mid-run, asynchronously between edges -> pred_hit drops to 0 and counters read 0 before the next clk edge.
- Counter saturation: force branch_count near all-ones (PERF_W=4 build), issue 20 updates -> branch_count holds at 15.
